mem_access_ctrl: RTL and testbench

Memory access sequencer and two-port arbiter for the 512-word memory unit. It sits between the CPU's requesters and the MAR/MDR/memory datapath. It serialises one instruction-fetch port (read-only) and one data port (read/write) onto that datapath, and generates the MAR load, MDR load, Read_from_mem and Write strobes. Requesters never touch the strobes directly; each sees a simple req/ack handshake with a fixed access latency.

---
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: arbitrates one fetch port and one data port onto the
// MAR/MDR/memory datapath and generates its load, read and write strobes.
module mem_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  input  logic [DATA_W-1:0] mdr_q,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              MAR_rd,
  output logic              MDR_rd,
  output logic              Read,
  output logic              Write,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD,
    S_WDAT,
    S_WR,
    S_DONE
  } state_t;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_t;

  state_t            state_q, state_d;
  port_t             gnt_q, gnt_d;
  port_t             last_q, last_d;
  port_t             pick;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Round-robin on a tie: the port that did not win last time goes first.
  always_comb begin
    if (f_req && d_req) pick = (last_q == PORT_D) ? PORT_F : PORT_D;
    else                pick = d_req ? PORT_D : PORT_F;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
          gnt_d   = pick;
          last_d  = pick;
          we_d    = (pick == PORT_D) && d_we;
          addr_d  = (pick == PORT_D) ? d_addr : f_addr;
          wdata_d = d_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR:  state_d = we_q ? S_WDAT : S_RD;
      S_RD:    state_d = S_DONE;
      S_WDAT:  state_d = S_WR;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignments so each one samples the
  // pre-edge value of every other flop regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= PORT_F;
      last_q  <= PORT_D;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Moore outputs: decoded from the state register only, so an asynchronous
  // reset clears every strobe immediately.
  always_comb begin
    bus_out   = '0;
    bus_drive = 1'b0;
    MAR_rd    = 1'b0;
    MDR_rd    = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        bus_out   = DATA_W'(addr_q);
        bus_drive = 1'b1;
        MAR_rd    = 1'b1;
      end
      S_RD: begin
        Read   = 1'b1;
        MDR_rd = 1'b1;
      end
      S_WDAT: begin
        bus_out   = wdata_q;
        bus_drive = 1'b1;
        MDR_rd    = 1'b1;
      end
      S_WR:    Write = 1'b1;
      S_DONE: begin
        f_ack = (gnt_q == PORT_F);
        d_ack = (gnt_q == PORT_D);
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign f_rdata = mdr_q;
  assign d_rdata = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a stand-in MAR/MDR/memory datapath,
// a per-cycle vector table, directed corner sequences and a random phase.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int WORDS  = 512;

  // Expected strobe patterns, bit order {MAR_rd,MDR_rd,Read,Write,bus_drive,busy,f_ack,d_ack}
  localparam logic [7:0] E_IDLE = 8'b0000_0000;
  localparam logic [7:0] E_ADDR = 8'b1000_1100;
  localparam logic [7:0] E_RD   = 8'b0110_0100;
  localparam logic [7:0] E_WDAT = 8'b0100_1100;
  localparam logic [7:0] E_WR   = 8'b0001_0100;
  localparam logic [7:0] E_DF   = 8'b0000_0110;
  localparam logic [7:0] E_DD   = 8'b0000_0101;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_req, d_req, d_we;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              f_ack, d_ack;
  logic [DATA_W-1:0] f_rdata, d_rdata, mdr_q, bus_out;
  logic              bus_drive, MAR_rd, MDR_rd, Read, Write, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mdr_q(mdr_q), .bus_out(bus_out), .bus_drive(bus_drive),
    .MAR_rd(MAR_rd), .MDR_rd(MDR_rd), .Read(Read), .Write(Write), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 510) return 32'd510;
    return 32'(i) * 32'h9E37_79B9 + 32'h0BAD_F00D;
  endfunction

  // Stand-in datapath: MAR, MDR and the 512-word memory.
  logic              mem_init;
  logic [DATA_W-1:0] dp_mem [WORDS];
  logic [ADDR_W-1:0] mar;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < WORDS; i++) dp_mem[i] <= init_word(i);
    end else begin
      if (MAR_rd) mar <= bus_out[ADDR_W-1:0];
      if (MDR_rd) mdr_q <= Read ? dp_mem[mar] : (bus_drive ? bus_out : '0);
      if (Write)  dp_mem[mar] <= mdr_q;
    end
  end

  logic [DATA_W-1:0] ref_mem [WORDS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] strobes();
    return {MAR_rd, MDR_rd, Read, Write, bus_drive, busy, f_ack, d_ack};
  endfunction

  task automatic wait_ack(input int budget, output int n, output logic [1:0] who);
    n   = -1;
    who = 2'b00;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (f_ack || d_ack) begin
        n   = c;
        who = {f_ack, d_ack};
        break;
      end
    end
  endtask

  typedef struct {
    logic              f_req, d_req, d_we;
    logic [ADDR_W-1:0] f_addr, d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [7:0]        exp_strb;
    logic [DATA_W-1:0] exp_bus;
    logic [1:0]        chk_port;   // 0 none, 1 fetch rdata, 2 data rdata
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic fr, input logic dr, input logic we,
                              input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] da,
                              input logic [DATA_W-1:0] wd, input logic [7:0] es,
                              input logic [DATA_W-1:0] eb, input logic [1:0] cp,
                              input logic [DATA_W-1:0] er);
    vec_t v;
    v.f_req = fr; v.d_req = dr; v.d_we = we;
    v.f_addr = fa; v.d_addr = da; v.d_wdata = wd;
    v.exp_strb = es; v.exp_bus = eb; v.chk_port = cp; v.exp_rd = er;
    return v;
  endfunction

  vec_t vecs [13];

  // Transaction-level reference for the random phase.
  logic              m_active, m_port, m_we, m_last;
  int                m_k, m_lat;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return ADDR_W'($urandom);
    return ADDR_W'($urandom_range(0, 15));
  endfunction

  initial begin
    int          n;
    logic [1:0]  who;
    logic        exp_fa, exp_da;

    reset = 1'b1; mem_init = 1'b1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    repeat (2) tick();
    check("reset_strobes", strobes(), E_IDLE);
    check("reset_bus_out", bus_out, 0);
    mem_init = 1'b0;
    reset    = 1'b0;
    tick();
    check("idle_strobes", strobes(), E_IDLE);

    // Fetch 510, write 190 to 45, read 45 back; each row is inputs then post-edge outputs.
    vecs[0]  = mk(1, 0, 0, 510, 0,  0,   E_ADDR, 510, 2'd0, 0);
    vecs[1]  = mk(1, 0, 0, 510, 0,  0,   E_RD,   0,   2'd0, 0);
    vecs[2]  = mk(1, 0, 0, 510, 0,  0,   E_DF,   0,   2'd1, 510);
    vecs[3]  = mk(0, 0, 0, 0,   0,  0,   E_IDLE, 0,   2'd0, 0);
    vecs[4]  = mk(0, 1, 1, 0,   45, 190, E_ADDR, 45,  2'd0, 0);
    vecs[5]  = mk(0, 1, 1, 0,   45, 190, E_WDAT, 190, 2'd0, 0);
    vecs[6]  = mk(0, 1, 1, 0,   45, 190, E_WR,   0,   2'd0, 0);
    vecs[7]  = mk(0, 1, 1, 0,   45, 190, E_DD,   0,   2'd0, 0);
    vecs[8]  = mk(0, 0, 0, 0,   0,  0,   E_IDLE, 0,   2'd0, 0);
    vecs[9]  = mk(0, 1, 0, 0,   45, 0,   E_ADDR, 45,  2'd0, 0);
    vecs[10] = mk(0, 1, 0, 0,   45, 0,   E_RD,   0,   2'd0, 0);
    vecs[11] = mk(0, 1, 0, 0,   45, 0,   E_DD,   0,   2'd2, 190);
    vecs[12] = mk(0, 0, 0, 0,   0,  0,   E_IDLE, 0,   2'd0, 0);
    for (int i = 0; i < 13; i++) begin
      f_req = vecs[i].f_req; d_req = vecs[i].d_req; d_we = vecs[i].d_we;
      f_addr = vecs[i].f_addr; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      tick();
      check($sformatf("vec%0d_strobes", i), strobes(), vecs[i].exp_strb);
      if (vecs[i].exp_strb[3]) check($sformatf("vec%0d_bus_out", i), bus_out, vecs[i].exp_bus);
      if (vecs[i].chk_port == 2'd1) check($sformatf("vec%0d_f_rdata", i), f_rdata, vecs[i].exp_rd);
      if (vecs[i].chk_port == 2'd2) check($sformatf("vec%0d_d_rdata", i), d_rdata, vecs[i].exp_rd);
    end
    ref_mem[45] = 32'd190;

    // Reset in the middle of WDAT: strobes drop at once, no ack follows.
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'd100; d_wdata = 32'hDEAD_BEEF;
    tick();
    tick();
    check("midwdat_before_reset", strobes(), E_WDAT);
    #2 reset = 1'b1;
    #1;
    check("midwdat_async_clear", strobes(), E_IDLE);
    check("midwdat_bus_out", bus_out, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("midwdat_no_ack", {busy, d_ack}, 2'b00);
    end

    // Tie from reset: fetch first; fetch held, so the IDLE tie goes to data, then fetch again.
    f_req = 1'b1; f_addr = 9'd3; d_req = 1'b1; d_we = 1'b0; d_addr = 9'd7;
    wait_ack(10, n, who);
    check("tie_first_latency", n, 3);
    check("tie_first_is_fetch", who, 2'b10);
    check("tie_first_f_rdata", f_rdata, ref_mem[3]);
    wait_ack(10, n, who);
    check("tie_second_latency", n, 4);
    check("tie_second_is_data", who, 2'b01);
    check("tie_second_d_rdata", d_rdata, ref_mem[7]);
    d_req = 1'b0;
    wait_ack(10, n, who);
    check("held_fetch_latency", n, 4);
    check("held_fetch_is_fetch", who, 2'b10);
    check("held_fetch_f_rdata", f_rdata, ref_mem[3]);
    f_req = 1'b0;
    tick();
    check("after_held_idle", strobes(), E_IDLE);

    // Random phase against the transaction-level reference.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_active = 1'b0; m_last = 1'b1; m_k = 0; m_lat = 0;
    m_port = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (m_active) begin
        m_k++;
        if (m_k == m_lat + 1) m_active = 1'b0;
      end else if (f_req || d_req) begin
        if (f_req && d_req) m_port = ~m_last;
        else                m_port = d_req;
        m_last   = m_port;
        m_active = 1'b1;
        m_k      = 1;
        m_we     = m_port && d_we;
        m_addr   = m_port ? d_addr : f_addr;
        m_wdata  = d_wdata;
        m_lat    = m_we ? 4 : 3;
      end
      tick();
      exp_fa = m_active && (m_k == m_lat) && !m_port;
      exp_da = m_active && (m_k == m_lat) && m_port;
      check("rand_busy", busy, m_active);
      check("rand_acks", {f_ack, d_ack}, {exp_fa, exp_da});
      check("rand_strobe_excl", ($countones({MAR_rd, MDR_rd, Write}) <= 1), 1'b1);
      check("rand_write_vs_drive", Write && bus_drive, 1'b0);
      if (exp_fa) check("rand_f_rdata", f_rdata, ref_mem[m_addr]);
      if (exp_da && !m_we) check("rand_d_rdata", d_rdata, ref_mem[m_addr]);
      if (exp_da && m_we) ref_mem[m_addr] = m_wdata;

      if (f_ack) f_req = 1'b0;
      else if (!f_req && $urandom_range(0, 2) == 0) begin
        f_req  = 1'b1;
        f_addr = rand_addr();
      end
      if (d_ack) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
